// File: rtl/parity_mem_writer.sv
// parity_mem_writer: fills a two-bank 8x8 data+parity memory from a valid/ready byte stream.
// Latency: 1 cycle from accept to registered write strobe; addresses from a wrapping counter.
// Backpressure: in_ready is high only in FILL and drops after the 16th byte; define PARITY_INJECT_EN for inj_en/inj_addr.
module parity_mem_writer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
`ifdef PARITY_INJECT_EN
   input  logic [ADDR_W-1:0] inj_addr,
   input  logic              inj_en,
`endif
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_parity,
   output logic [ADDR_W:0]   count,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic              inject;

`ifdef PARITY_INJECT_EN
   assign inject = inj_en && (addr == inj_addr);
`else
   assign inject = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr      <= '0;
         count     <= '0;
         in_ready  <= 1'b0;
         done      <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_parity <= 1'b0;
      end else if (clear) begin
         // Abort wins over start and drops any byte presented this cycle.
         state    <= IDLE;
         addr     <= '0;
         count    <= '0;
         in_ready <= 1'b0;
         done     <= 1'b0;
         wr_en    <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= FILL;
                  addr     <= '0;
                  count    <= '0;
                  in_ready <= 1'b1;
               end
            end
            FILL: begin
               if (in_valid && in_ready) begin
                  wr_en     <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= in_data;
                  wr_parity <= (^in_data) ^ inject;
                  addr      <= addr + 1'b1;
                  count     <= count + 1'b1;
                  if (addr == LAST_ADDR) begin
                     state    <= FULL;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                  end
               end
            end
            FULL: begin
               if (start) begin
                  state    <= FILL;
                  addr     <= '0;
                  count    <= '0;
                  done     <= 1'b0;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parity_mem_writer.sv
// Bench for parity_mem_writer: scenario tasks drive bytes and compare observed writes
// against addresses/parities derived from the byte list (index mod 16, odd bit count).
module tb_parity_mem_writer;

   logic       clock = 1'b0;
   logic       reset;
   logic       start, clear, in_valid;
   logic [7:0] in_data;
   logic       in_ready, wr_en, wr_parity, done;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [4:0] count;
`ifdef PARITY_INJECT_EN
   logic [3:0] inj_addr;
   logic       inj_en;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {logic [3:0] a; logic [7:0] d; logic p;} wr_t;
   wr_t        obs[$];
   logic [7:0] bytes[$];

   parity_mem_writer dut (
      .clock(clock), .reset(reset), .start(start), .clear(clear),
      .in_data(in_data), .in_valid(in_valid),
`ifdef PARITY_INJECT_EN
      .inj_addr(inj_addr), .inj_en(inj_en),
`endif
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_parity(wr_parity), .count(count), .done(done)
   );

   always #5 clock = ~clock;

   // wr_en lasts exactly one cycle, so each pulse is seen at exactly one falling edge.
   always @(negedge clock) if (wr_en === 1'b1) obs.push_back('{wr_addr, wr_data, wr_parity});

   function automatic logic ref_par(input logic [7:0] d, input logic [3:0] a);
      logic p;
      p = ($countones(d) % 2) == 1;
`ifdef PARITY_INJECT_EN
      if (inj_en && a == inj_addr) p = ~p;
`endif
      return p;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic put_byte(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      n_cmp++; if ({wr_en, wr_addr, wr_data, wr_parity, count, done, in_ready} !== 21'd0) begin
         n_err++; $display("FAIL reset_outputs: got %h want 0", {wr_en, wr_addr, wr_data, wr_parity, count, done, in_ready});
      end
      tick(2);
      reset = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick(3);
      in_valid = 1'b0;
      tick(1);
      n_cmp++; if (obs.size() !== 0) begin
         n_err++; $display("FAIL idle_ignores_valid: got %0d writes want 0", obs.size());
      end
      n_cmp++; if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL idle_in_ready: got %b want 0", in_ready);
      end
   endtask

   task automatic test_full_fill();
      obs.delete(); bytes.delete();
      pulse_start();
      n_cmp++; if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL fill_in_ready: got %b want 1", in_ready);
      end
      for (int i = 0; i < 16; i++) bytes.push_back(8'(i * 8'h11));
      foreach (bytes[i]) put_byte(bytes[i]);
      n_cmp++; if (done !== 1'b1 || count !== 5'd16 || in_ready !== 1'b0) begin
         n_err++; $display("FAIL full_flags: got done=%b count=%0d rdy=%b want 1 16 0", done, count, in_ready);
      end
      in_valid = 1'b1; in_data = 8'hEE;
      tick(3);
      in_valid = 1'b0;
      tick(1);
      n_cmp++; if (obs.size() !== 16 || count !== 5'd16) begin
         n_err++; $display("FAIL no_17th: got %0d writes count=%0d want 16 16", obs.size(), count);
      end
      for (int i = 0; i < obs.size() && i < 16; i++) begin
         n_cmp++; if (obs[i].a !== 4'(i) || obs[i].d !== bytes[i] || obs[i].p !== ref_par(bytes[i], 4'(i))) begin
            n_err++; $display("FAIL fill_write[%0d]: got a=%0d d=%h p=%b want a=%0d d=%h p=%b",
                              i, obs[i].a, obs[i].d, obs[i].p, i, bytes[i], ref_par(bytes[i], 4'(i)));
         end
      end
   endtask

   task automatic test_parity();
      obs.delete(); bytes.delete();
      pulse_start();
      bytes.push_back(8'h1F); bytes.push_back(8'h31);
      for (int i = 2; i < 16; i++) bytes.push_back(8'($urandom));
      foreach (bytes[i]) put_byte(bytes[i]);
      tick(1);
      n_cmp++; if (obs.size() !== 16) begin
         n_err++; $display("FAIL parity_len: got %0d want 16", obs.size());
      end
      n_cmp++; if (obs.size() < 2 || obs[0].p !== 1'b1 || obs[1].p !== 1'b1 || obs[0].a[3] !== 1'b0 || obs[1].a[3] !== 1'b0) begin
         n_err++; $display("FAIL parity_odd: got p0/p1 and bank bits not all as required, want p=1,1 bank=0,0");
      end
      for (int i = 2; i < obs.size() && i < 16; i++) begin
         n_cmp++; if (obs[i].a !== 4'(i) || obs[i].d !== bytes[i] || obs[i].p !== ref_par(bytes[i], 4'(i))) begin
            n_err++; $display("FAIL parity_write[%0d]: got a=%0d d=%h p=%b want a=%0d d=%h p=%b",
                              i, obs[i].a, obs[i].d, obs[i].p, i, bytes[i], ref_par(bytes[i], 4'(i)));
         end
      end
   endtask

   task automatic test_stall();
      obs.delete(); bytes.delete();
      pulse_start();
      for (int i = 0; i < 16; i++) bytes.push_back(8'($urandom));
      for (int i = 0; i < 5; i++) put_byte(bytes[i]);
      tick(3);
      n_cmp++; if (obs.size() !== 5 || count !== 5'd5) begin
         n_err++; $display("FAIL stall_gap: got %0d writes count=%0d want 5 5", obs.size(), count);
      end
      for (int i = 5; i < 16; i++) put_byte(bytes[i]);
      tick(1);
      n_cmp++; if (obs.size() < 6 || obs[5].a !== 4'd5 || obs[5].d !== bytes[5]) begin
         n_err++; $display("FAIL stall_sixth: got %0d writes, sixth not at addr 5 with byte %h", obs.size(), bytes[5]);
      end
      n_cmp++; if (obs.size() !== 16 || done !== 1'b1) begin
         n_err++; $display("FAIL stall_total: got %0d writes done=%b want 16 1", obs.size(), done);
      end
   endtask

   task automatic test_clear();
      obs.delete(); bytes.delete();
      pulse_start();
      for (int i = 0; i < 9; i++) put_byte(8'($urandom));
      clear = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hC3;
      tick(1);
      clear = 1'b0; start = 1'b0;
      n_cmp++; if (count !== 5'd0 || in_ready !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
         n_err++; $display("FAIL clear_state: got count=%0d rdy=%b done=%b wr_en=%b want 0 0 0 0", count, in_ready, done, wr_en);
      end
      tick(2);
      in_valid = 1'b0;
      n_cmp++; if (obs.size() !== 9) begin
         n_err++; $display("FAIL clear_drop: got %0d writes want 9", obs.size());
      end
      obs.delete();
      pulse_start();
      for (int i = 0; i < 16; i++) bytes.push_back(8'($urandom));
      foreach (bytes[i]) put_byte(bytes[i]);
      tick(1);
      n_cmp++; if (obs.size() !== 16 || obs[0].a !== 4'd0 || obs[15].a !== 4'd15 || obs[0].d !== bytes[0]) begin
         n_err++; $display("FAIL clear_refill: got %0d writes, first addr/data not 0/%h", obs.size(), bytes[0]);
      end
   endtask

   task automatic test_reset_mid();
      obs.delete(); bytes.delete();
      pulse_start();
      for (int i = 0; i < 7; i++) put_byte(8'hFF - 8'(i));
      #2 reset = 1'b0;
      #1;
      n_cmp++; if ({wr_en, wr_addr, wr_data, wr_parity, count, done, in_ready} !== 21'd0) begin
         n_err++; $display("FAIL reset_mid: got %h want 0", {wr_en, wr_addr, wr_data, wr_parity, count, done, in_ready});
      end
      tick(1);
      reset = 1'b1;
      tick(1);
      obs.delete();
      pulse_start();
      for (int i = 0; i < 16; i++) bytes.push_back(8'($urandom));
      for (int i = 0; i < 15; i++) put_byte(bytes[i]);
      n_cmp++; if (done !== 1'b0 || count !== 5'd15) begin
         n_err++; $display("FAIL reset_refill_15: got done=%b count=%0d want 0 15", done, count);
      end
      put_byte(bytes[15]);
      tick(1);
      n_cmp++; if (done !== 1'b1 || obs.size() !== 16 || obs[0].a !== 4'd0) begin
         n_err++; $display("FAIL reset_refill_16: got done=%b writes=%0d want 1 16 from addr 0", done, obs.size());
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         obs.delete(); bytes.delete();
         pulse_start();
         for (int i = 0; i < 16; i++) begin
            bytes.push_back(8'($urandom));
            put_byte(bytes[i]);
            if ($urandom_range(3) == 0) tick($urandom_range(3, 1));
         end
         tick(1);
         n_cmp++; if (obs.size() !== 16) begin
            n_err++; $display("FAIL b2b_len[%0d]: got %0d want 16", f, obs.size());
         end
         for (int i = 0; i < obs.size() && i < 16; i++) begin
            n_cmp++; if (obs[i].a !== 4'(i) || obs[i].d !== bytes[i] || obs[i].p !== ref_par(bytes[i], 4'(i))) begin
               n_err++; $display("FAIL b2b_write[%0d][%0d]: got a=%0d d=%h p=%b want a=%0d d=%h p=%b",
                                 f, i, obs[i].a, obs[i].d, obs[i].p, i, bytes[i], ref_par(bytes[i], 4'(i)));
            end
         end
      end
   endtask

`ifdef PARITY_INJECT_EN
   task automatic test_inject();
      obs.delete(); bytes.delete();
      inj_en = 1'b1; inj_addr = 4'd10;
      pulse_start();
      for (int i = 0; i < 16; i++) put_byte(8'hAA);
      tick(1);
      for (int i = 0; i < obs.size() && i < 16; i++) begin
         n_cmp++; if (obs[i].p !== ((i == 10) ? 1'b1 : 1'b0)) begin
            n_err++; $display("FAIL inject[%0d]: got p=%b want %b", i, obs[i].p, (i == 10));
         end
      end
      n_cmp++; if (obs.size() !== 16) begin
         n_err++; $display("FAIL inject_len: got %0d want 16", obs.size());
      end
      inj_en = 1'b0;
   endtask
`endif

   initial begin
      start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
`ifdef PARITY_INJECT_EN
      inj_en = 1'b0; inj_addr = 4'd0;
`endif
      test_reset();
      test_full_fill();
      test_parity();
      test_stall();
      test_clear();
      test_reset_mid();
      test_back_to_back();
`ifdef PARITY_INJECT_EN
      test_inject();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
